// File: rtl/stack_unit_p.sv
// Purpose: parametrised operand stack (push/pop/replace/dup/swap/ALU write-back) with sticky error flags.
// Latency: every operation commits on one rising edge; outputs are combinational from registered state.
// Backpressure: none, always ready; rejected operations only raise overflow/underflow.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   push, pop, alu_wb,      operation strobes, priority alu_wb > push/pop > dup > swap
//   dup, swap, clear_err
//   data_in, result         push data and ALU write-back data
//   data_out_1st/_2nd       top and next entries, zero when not valid
//   count, empty, full      occupancy status
//   overflow, underflow     sticky error flags
module stack_unit_p #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             alu_wb,
  input  logic             dup,
  input  logic             swap,
  input  logic             clear_err,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] data_out_1st,
  output logic [WIDTH-1:0] data_out_2nd,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_TWO   = (PTR_W+1)'(2);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] IDX_ONE   = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  // Index of the next free slot, the top entry and the entry below the top.
  // When the stack is full cnt_idx wraps to 0, but it is never written then.
  logic [PTR_W-1:0] cnt_idx;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] nxt_idx;

  logic             is_empty;
  logic             is_full;
  logic             has_two;

  logic [PTR_W:0]   cnt_nxt;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_dat;
  logic             swp_en;
  logic             ovf_set;
  logic             udf_set;

  assign cnt_idx  = count[PTR_W-1:0];
  assign top_idx  = cnt_idx - IDX_ONE;
  assign nxt_idx  = top_idx - IDX_ONE;
  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_DEPTH);
  assign has_two  = (count >= CNT_TWO);

  // Operation decode. The if/else chain encodes the fixed priority, so any
  // lower-priority strobe in the same cycle is silently ignored.
  always_comb begin
    cnt_nxt = count;
    wr_en   = 1'b0;
    wr_idx  = cnt_idx;
    wr_dat  = data_in;
    swp_en  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (alu_wb) begin
      // Two operands collapse into one: result overwrites the lower operand.
      if (has_two) begin
        wr_en   = 1'b1;
        wr_idx  = nxt_idx;
        wr_dat  = result;
        cnt_nxt = count - CNT_ONE;
      end else begin
        udf_set = 1'b1;
      end
    end else if (push && pop) begin
      // Replace the top in place; on an empty stack this degrades to a push.
      wr_en = 1'b1;
      if (!is_empty) begin
        wr_idx = top_idx;
      end else begin
        wr_idx  = cnt_idx;
        cnt_nxt = count + CNT_ONE;
      end
    end else if (push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        wr_idx  = cnt_idx;
        cnt_nxt = count + CNT_ONE;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pop) begin
      if (!is_empty) begin
        cnt_nxt = count - CNT_ONE;
      end else begin
        udf_set = 1'b1;
      end
    end else if (dup) begin
      if (is_empty) begin
        udf_set = 1'b1;
      end else if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = cnt_idx;
        wr_dat  = mem[top_idx];
        cnt_nxt = count + CNT_ONE;
      end
    end else if (swap) begin
      if (has_two) begin
        swp_en = 1'b1;
      end else begin
        udf_set = 1'b1;
      end
    end
  end

  // Memory lives in the reset block but is never reset: a reset at the edge
  // simply suppresses the pending write, and stale contents stay masked by count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      // Set wins over a simultaneous clear.
      overflow  <= ovf_set | (overflow  & ~clear_err);
      underflow <= udf_set | (underflow & ~clear_err);
      if (swp_en) begin
        mem[top_idx] <= mem[nxt_idx];
        mem[nxt_idx] <= mem[top_idx];
      end else if (wr_en) begin
        mem[wr_idx] <= wr_dat;
      end
    end
  end

  assign data_out_1st = is_empty ? '0 : mem[top_idx];
  assign data_out_2nd = has_two  ? mem[nxt_idx] : '0;
  assign empty        = is_empty;
  assign full         = is_full;

endmodule

// File: tb/tb_stack_unit_p.sv
module tb_stack_unit_p;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             push = 1'b0, pop = 1'b0, alu_wb = 1'b0;
  logic             dup = 1'b0, swap = 1'b0, clear_err = 1'b0;
  logic [WIDTH-1:0] data_in = '0, result = '0;
  logic [WIDTH-1:0] data_out_1st, data_out_2nd;
  logic [PTR_W:0]   count;
  logic             empty, full, overflow, underflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the stack as a queue, back = top.
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;

  stack_unit_p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .alu_wb       (alu_wb),
    .dup          (dup),
    .swap         (swap),
    .clear_err    (clear_err),
    .data_in      (data_in),
    .result       (result),
    .data_out_1st (data_out_1st),
    .data_out_2nd (data_out_2nd),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Applies one edge worth of strobes to the model, straight from the stack rules.
  task automatic model_apply();
    logic             so, su;
    logic [WIDTH-1:0] t;
    int               n;
    so = 1'b0;
    su = 1'b0;
    n  = q.size();
    if (alu_wb) begin
      if (n >= 2) begin
        void'(q.pop_back());
        void'(q.pop_back());
        q.push_back(result);
      end else su = 1'b1;
    end else if (push && pop) begin
      if (n >= 1) q[n-1] = data_in;
      else        q.push_back(data_in);
    end else if (push) begin
      if (n < DEPTH) q.push_back(data_in);
      else           so = 1'b1;
    end else if (pop) begin
      if (n >= 1) void'(q.pop_back());
      else        su = 1'b1;
    end else if (dup) begin
      if (n == 0)          su = 1'b1;
      else if (n == DEPTH) so = 1'b1;
      else                 q.push_back(q[n-1]);
    end else if (swap) begin
      if (n >= 2) begin
        t      = q[n-1];
        q[n-1] = q[n-2];
        q[n-2] = t;
      end else su = 1'b1;
    end
    if (so) m_ovf = 1'b1; else if (clear_err) m_ovf = 1'b0;
    if (su) m_udf = 1'b1; else if (clear_err) m_udf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".out1"},  64'(data_out_1st), (n >= 1) ? 64'(q[n-1]) : 64'd0);
    chk({tag, ".out2"},  64'(data_out_2nd), (n >= 2) ? 64'(q[n-2]) : 64'd0);
    chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tag, ".full"},  64'(full),  64'(n == DEPTH));
    chk({tag, ".ovf"},   64'(overflow),  64'(m_ovf));
    chk({tag, ".udf"},   64'(underflow), 64'(m_udf));
  endtask

  // Called #1 after a rising edge: drive strobes, take one edge, compare.
  task automatic step(input string tag, input logic p, input logic po, input logic a,
                      input logic d, input logic s, input logic c,
                      input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] res);
    push = p; pop = po; alu_wb = a; dup = d; swap = s; clear_err = c;
    data_in = di; result = res;
    @(posedge clock);
    model_apply();
    #1;
    check_all(tag);
  endtask

  task automatic idle_strobes();
    push = 1'b0; pop = 1'b0; alu_wb = 1'b0; dup = 1'b0; swap = 1'b0; clear_err = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    idle_strobes();
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #1;
    model_reset();
    check_all("por");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic push/pop.
    step("push11", 1, 0, 0, 0, 0, 0, 32'h11, 0);
    step("push22", 1, 0, 0, 0, 0, 0, 32'h22, 0);
    step("push33", 1, 0, 0, 0, 0, 0, 32'h33, 0);
    chk("tp1.out1", 64'(data_out_1st), 64'h33);
    chk("tp1.out2", 64'(data_out_2nd), 64'h22);
    step("pop1", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("tp1.cnt", 64'(count), 64'd2);

    // Fill, overflow, clear.
    do_reset("rst2");
    for (int i = 1; i <= DEPTH; i++) step("fill", 1, 0, 0, 0, 0, 0, WIDTH'(i), 0);
    step("ovf_push", 1, 0, 0, 0, 0, 0, 32'h99, 0);
    chk("tp2.full", 64'(full), 64'd1);
    chk("tp2.out1", 64'(data_out_1st), 64'd16);
    chk("tp2.ovf",  64'(overflow), 64'd1);
    step("dup_full", 0, 0, 0, 1, 0, 0, 0, 0);
    step("clr", 0, 0, 0, 0, 0, 1, 0, 0);
    chk("tp2.clr", 64'(overflow), 64'd0);
    // Error and clear in the same cycle: set wins.
    step("ovf_clr", 1, 0, 0, 0, 0, 1, 32'h77, 0);
    chk("tp2.setwins", 64'(overflow), 64'd1);

    // ALU write-back.
    do_reset("rst3");
    step("p5", 1, 0, 0, 0, 0, 0, 5, 0);
    step("p7", 1, 0, 0, 0, 0, 0, 7, 0);
    step("alu", 0, 0, 1, 0, 0, 0, 0, 12);
    chk("tp3.out1", 64'(data_out_1st), 64'd12);
    step("alu_udf", 1, 1, 1, 1, 1, 0, 32'hDEAD, 13);
    chk("tp3.udf", 64'(underflow), 64'd1);

    // Replace.
    do_reset("rst4");
    step("pA", 1, 0, 0, 0, 0, 0, 32'hA, 0);
    step("repl", 1, 1, 0, 0, 0, 0, 32'hB, 0);
    chk("tp4.out1", 64'(data_out_1st), 64'hB);
    do_reset("rst4b");
    step("repl_empty", 1, 1, 0, 0, 0, 0, 32'hB, 0);
    chk("tp4.udf", 64'(underflow), 64'd0);

    // Swap, dup, priority.
    do_reset("rst5");
    step("p1", 1, 0, 0, 0, 0, 0, 1, 0);
    step("p2", 1, 0, 0, 0, 0, 0, 2, 0);
    step("swap", 0, 0, 0, 0, 1, 0, 0, 0);
    chk("tp5.out1", 64'(data_out_1st), 64'd1);
    chk("tp5.out2", 64'(data_out_2nd), 64'd2);
    step("dup", 0, 0, 0, 1, 0, 0, 0, 0);
    chk("tp5.cnt", 64'(count), 64'd3);
    step("swap_pop", 0, 1, 0, 0, 1, 0, 0, 0);
    chk("tp5.cnt2", 64'(count), 64'd2);
    step("dup_swap", 0, 0, 0, 1, 1, 0, 0, 0);

    // Underflow on empty, then reset mid-cycle aborting a push.
    do_reset("rst6");
    step("pop_empty", 0, 1, 0, 0, 0, 0, 0, 0);
    step("swap_empty", 0, 0, 0, 0, 1, 0, 0, 0);
    step("dup_empty", 0, 0, 0, 1, 0, 0, 0, 0);
    push = 1'b1; data_in = 32'h5;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    @(posedge clock);
    #1;
    check_all("midrst.edge");
    idle_strobes();
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic p, po, a, d, s, c;
      r  = $urandom_range(99);
      p  = ($urandom_range(99) < 45);
      po = ($urandom_range(99) < 35);
      a  = ($urandom_range(99) < 12);
      d  = ($urandom_range(99) < 15);
      s  = ($urandom_range(99) < 15);
      c  = ($urandom_range(99) < 10);
      if (r < 2) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", p, po, a, d, s, c, $urandom, $urandom);
      end
    end

    idle_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_unit_p.md
# stack_unit_p

Parametrised operand stack for the MIPS stack-machine datapath. It is the next generation of the fixed 32x16 operand stack, generalised in data width and depth. It adds replace, duplicate and swap operations, an occupancy count, full/empty status, and sticky overflow/underflow error flags. It sits between the decode/control unit, which issues stack operations, and the ALU, which reads the top two entries and writes its result back via `alu_wb`.

## Interface
- `WIDTH`, 32, data word width in bits (≥1).
- `DEPTH`, 16, number of entries; power of two, ≥4.
- `PTR_W`, $clog2(DEPTH), local/derived; count is `PTR_W+1` bits wide.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  push `data_in`.
- `pop`  in  1  discard the top entry.
- `alu_wb`  in  1  ALU completion: pop two entries, push `result`.
- `dup`  in  1  push a copy of the top entry.
- `swap`  in  1  exchange the top and next entries.
- `clear_err`  in  1  clear the sticky error flags.
- `data_in`  in  WIDTH  push data.
- `result`  in  WIDTH  ALU result for `alu_wb`.
- `data_out_1st`  out  WIDTH  top entry; 0 if count==0.
- `data_out_2nd`  out  WIDTH  entry below top; 0 if count<2.
- `count`  out  PTR_W+1  occupancy, 0..DEPTH.
- `empty`  out  1  count==0.
- `full`  out  1  count==DEPTH.
- `overflow`  out  1  sticky; set by a rejected op that would exceed DEPTH.
- `underflow`  out  1  sticky; set by a rejected op lacking operands.

## Operation
- State: `mem[DEPTH]` (not reset), `count` register, two sticky flags.
- Entry `i` is valid for `i < count`; the top is `mem[count-1]`.
- Exactly one operation executes per cycle, selected by fixed priority: `alu_wb` > (`push`/`pop`) > `dup` > `swap`. Lower-priority strobes in the same cycle are ignored, with no error.
- `alu_wb`:
  - count ≥ 2: `mem[count-2]` <= `result`, count−1.
  - Otherwise: no change, underflow set.
- `push` only:
  - count < DEPTH: `mem[count]` <= `data_in`, count+1.
  - full: no change, overflow set.
- `pop` only:
  - count ≥ 1: count−1; memory is untouched.
  - empty: no change, underflow set.
- `push`+`pop` together (replace):
  - count ≥ 1: `mem[count-1]` <= `data_in`, count unchanged.
  - empty: behaves as a plain push; no underflow.
- `dup`:
  - 1 ≤ count < DEPTH: `mem[count]` <= `mem[count-1]`, count+1.
  - empty: underflow, no change.
  - full: overflow, no change.
- `swap`:
  - count ≥ 2: top and next are exchanged in one edge, count unchanged.
  - Otherwise: underflow, no change.
- Error flags:
  - A rejected operation never modifies memory or count.
  - `clear_err` clears both flags.
  - If an error and `clear_err` occur in the same cycle, the flag is set (set wins).
- `count` never wraps. DEPTH is representable only because count is `PTR_W+1` bits wide.

## Timing
- Reset (asynchronous, immediate): count=0, overflow=0, underflow=0. Outputs: `data_out_1st`=0, `data_out_2nd`=0, empty=1, full=0.
- Memory contents are unspecified after reset, but are masked by the count-gated read outputs.
- Reset asserted in the middle of a sequence aborts the pending edge update. No write lands.
- All operations commit on a single rising edge. Outputs are combinational from the registered state, so new values are visible one cycle after the strobe is sampled, with no bypass.
- The block is always ready. There is no backpressure; errors are reported only through the flags.
- Strobes are level-sampled each edge. A strobe held for N cycles performs N operations.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on three edges → count=3, out_1st=0x33, out_2nd=0x22. Then pop → count=2, out_1st=0x22.
- Push DEPTH values 1..16, then push 0x99 → full=1, count=16, out_1st=16, overflow=1. Assert `clear_err` → overflow=0.
- Stack [5, 7], `alu_wb` with result=12 → count=1, out_1st=12, out_2nd=0. A second `alu_wb` → underflow=1, count=1, out_1st=12.
- Stack [0xA], `push`+`pop` with data_in=0xB → count=1, out_1st=0xB. On an empty stack, the same input → count=1, underflow=0.
- Stack [1, 2]: `swap` → out_1st=1, out_2nd=2. Then `dup` → count=3, out_1st=1. Then `swap`+`pop` together → only the pop executes, count=2.
- Pop on an empty stack → underflow=1, count=0. Push 0x5 and assert `reset` mid-cycle before the edge → count=0, out_1st=0, flags=0 immediately.
